// File: rtl/io_port_pins_pkg.sv
// Shared constants and types for the PORTA/PORTB/PORTC pin stage.
// Holds the file-register addresses, bus/pin widths and the port decode helper.
package io_port_pins_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int IO_A_WIDTH  = 4;
  localparam int IO_B_WIDTH  = 8;
  localparam int IO_C_WIDTH  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_WIDTH  = 5;

  localparam logic [ADDR_WIDTH-1:0] PORTA_ADDR = 5'h05;
  localparam logic [ADDR_WIDTH-1:0] PORTB_ADDR = 5'h06;
  localparam logic [ADDR_WIDTH-1:0] PORTC_ADDR = 5'h07;

  // Instruction-cycle phase used by the surrounding core.
  typedef enum logic [1:0] {
    EX_Q1,
    EX_Q2,
    EX_Q3,
    EX_Q4
  } exState_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_A,
    SEL_B,
    SEL_C
  } portSel_t;

  // Full decode of all five address bits so unmapped addresses never alias a port.
  function automatic portSel_t decodePort(input logic [ADDR_WIDTH-1:0] addr);
    portSel_t sel;
    sel = SEL_NONE;
    case (addr)
      PORTA_ADDR: sel = SEL_A;
      PORTB_ADDR: sel = SEL_B;
      PORTC_ADDR: sel = SEL_C;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_port_pins_if.sv
// File-register bus between the datapath (master) and the port pin stage (slave).
interface io_port_pins_if;
  import io_port_pins_pkg::*;

  logic                  wrEn;
  logic                  rdEn;
  logic [ADDR_WIDTH-1:0] fileAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] portRdData;
  logic                  portHit;

  modport master (
    output wrEn,
    output rdEn,
    output fileAddr,
    output wrData,
    input  portRdData,
    input  portHit
  );

  modport slave (
    input  wrEn,
    input  rdEn,
    input  fileAddr,
    input  wrData,
    output portRdData,
    output portHit
  );

endinterface

// File: rtl/io_port_pins_sync.sv
// Multi-flop synchroniser bank for asynchronous pad inputs, cleared by async reset.
// STAGES is expected to be 2 or 3; dout lags din by exactly STAGES clocks.
module io_sync_bank #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stageQ [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stageQ[i] <= '0;
      end
    end else begin
      stageQ[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stageQ[i] <= stageQ[i-1];
      end
    end
  end

  assign dout = stageQ[STAGES-1];

endmodule

// File: rtl/io_port_pins.sv
// Pin-side stage after the TRIS block: port output latches, pad enables, input sync,
// file-read mux and the sticky PORTB input-change flag used for SLEEP wake-up.
module io_port_pins
  import io_port_pins_pkg::*;
#(
  parameter int DATA_WIDTH  = io_port_pins_pkg::DATA_WIDTH,
  parameter int IO_A_WIDTH  = io_port_pins_pkg::IO_A_WIDTH,
  parameter int IO_B_WIDTH  = io_port_pins_pkg::IO_B_WIDTH,
  parameter int IO_C_WIDTH  = io_port_pins_pkg::IO_C_WIDTH,
  parameter int SYNC_STAGES = io_port_pins_pkg::SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_port_pins_if.slave         bus,
  input  logic [IO_A_WIDTH-1:0] trisAReg,
  input  logic [IO_B_WIDTH-1:0] trisBReg,
  input  logic [IO_C_WIDTH-1:0] trisCReg,
  input  logic [IO_A_WIDTH-1:0] padAIn,
  input  logic [IO_B_WIDTH-1:0] padBIn,
  input  logic [IO_C_WIDTH-1:0] padCIn,
  output logic [IO_A_WIDTH-1:0] padAOut,
  output logic [IO_B_WIDTH-1:0] padBOut,
  output logic [IO_C_WIDTH-1:0] padCOut,
  output logic [IO_A_WIDTH-1:0] padAOe,
  output logic [IO_B_WIDTH-1:0] padBOe,
  output logic [IO_C_WIDTH-1:0] padCOe,
  output logic                  pbChange
);

  logic [IO_A_WIDTH-1:0] latchA;
  logic [IO_B_WIDTH-1:0] latchB;
  logic [IO_C_WIDTH-1:0] latchC;
  logic [IO_A_WIDTH-1:0] syncA;
  logic [IO_B_WIDTH-1:0] syncB;
  logic [IO_C_WIDTH-1:0] syncC;
  logic [IO_B_WIDTH-1:0] pbSnapshot;
  logic [IO_A_WIDTH-1:0] readA;
  logic [IO_B_WIDTH-1:0] readB;
  logic [IO_C_WIDTH-1:0] readC;
  portSel_t              portSel;
  logic                  pbRead;
  logic                  pbMismatch;
  logic                  unusedWrData;

  assign portSel      = decodePort(bus.fileAddr);
  assign unusedWrData = ^bus.wrData;

  io_sync_bank #(.WIDTH(IO_A_WIDTH), .STAGES(SYNC_STAGES)) syncBankA (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (padAIn),
    .dout  (syncA)
  );

  io_sync_bank #(.WIDTH(IO_B_WIDTH), .STAGES(SYNC_STAGES)) syncBankB (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (padBIn),
    .dout  (syncB)
  );

  io_sync_bank #(.WIDTH(IO_C_WIDTH), .STAGES(SYNC_STAGES)) syncBankC (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (padCIn),
    .dout  (syncC)
  );

  // Output latches; a write landing on the same edge as reset assertion is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latchA <= '0;
      latchB <= '0;
      latchC <= '0;
    end else if (bus.wrEn) begin
      case (portSel)
        SEL_A:   latchA <= bus.wrData[IO_A_WIDTH-1:0];
        SEL_B:   latchB <= bus.wrData[IO_B_WIDTH-1:0];
        SEL_C:   latchC <= bus.wrData[IO_C_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Drive enables fall immediately in reset rather than waiting for TRIS to settle.
  assign padAOe  = rst_n ? ~trisAReg : '0;
  assign padBOe  = rst_n ? ~trisBReg : '0;
  assign padCOe  = rst_n ? ~trisCReg : '0;
  assign padAOut = latchA;
  assign padBOut = latchB;
  assign padCOut = latchC;

  // Output pins read back the latch so a loaded pad cannot corrupt read-modify-write.
  assign readA = (syncA & trisAReg) | (latchA & ~trisAReg);
  assign readB = (syncB & trisBReg) | (latchB & ~trisBReg);
  assign readC = (syncC & trisCReg) | (latchC & ~trisCReg);

  always_comb begin
    bus.portRdData = '0;
    bus.portHit    = 1'b0;
    case (portSel)
      SEL_A: begin
        bus.portRdData = DATA_WIDTH'(readA);
        bus.portHit    = 1'b1;
      end
      SEL_B: begin
        bus.portRdData = DATA_WIDTH'(readB);
        bus.portHit    = 1'b1;
      end
      SEL_C: begin
        bus.portRdData = DATA_WIDTH'(readC);
        bus.portHit    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pbRead     = bus.rdEn && (portSel == SEL_B);
  assign pbMismatch = |((syncB ^ pbSnapshot) & trisBReg);

  // A fresh mismatch outranks the clearing read so no wake-up event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbSnapshot <= '0;
      pbChange   <= 1'b0;
    end else begin
      if (pbRead) begin
        pbSnapshot <= syncB;
      end
      if (pbMismatch) begin
        pbChange <= 1'b1;
      end else if (pbRead) begin
        pbChange <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_pins.sv
// Directed self-checking bench for io_port_pins with hand-computed expected values.
module tb_io_port_pins;
  import io_port_pins_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [IO_A_WIDTH-1:0] trisAReg, padAIn, padAOut, padAOe;
  logic [IO_B_WIDTH-1:0] trisBReg, padBIn, padBOut, padBOe;
  logic [IO_C_WIDTH-1:0] trisCReg, padCIn, padCOut, padCOe;
  logic                  pbChange;
  int                    checkCount;
  int                    failCount;

  io_port_pins_if bus();

  io_port_pins dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .trisAReg (trisAReg),
    .trisBReg (trisBReg),
    .trisCReg (trisCReg),
    .padAIn   (padAIn),
    .padBIn   (padBIn),
    .padCIn   (padCIn),
    .padAOut  (padAOut),
    .padBOut  (padBOut),
    .padCOut  (padCOut),
    .padAOe   (padAOe),
    .padBOe   (padBOe),
    .padCOe   (padCOe),
    .pbChange (pbChange)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one bus operation for a single clock edge, then release the strobes.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [4:0] addr,
                               input logic [7:0] data);
    bus.wrEn     = wr;
    bus.rdEn     = rd;
    bus.fileAddr = addr;
    bus.wrData   = data;
    @(negedge clk);
    bus.wrEn = 1'b0;
    bus.rdEn = 1'b0;
    #1;
  endtask

  initial begin
    checkCount   = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    trisAReg     = '0;
    trisBReg     = 8'h00;
    trisCReg     = 8'h00;
    padAIn       = '0;
    padBIn       = '0;
    padCIn       = '0;
    bus.wrEn     = 1'b0;
    bus.rdEn     = 1'b0;
    bus.fileAddr = 5'h00;
    bus.wrData   = 8'h00;

    #3;
    checkOutput("rstPadBOe", 32'(padBOe), 32'h00);
    checkOutput("rstPadAOe", 32'(padAOe), 32'h0);
    checkOutput("rstPadBOut", 32'(padBOut), 32'h00);
    checkOutput("rstPbChange", 32'(pbChange), 32'h0);
    stepClocks(2);
    rst_n = 1'b1;
    #1;
    checkOutput("relPadBOe", 32'(padBOe), 32'hFF);

    applyStimulus(1'b1, 1'b0, 5'h05, 8'hA5);
    checkOutput("wrPadAOut", 32'(padAOut), 32'h5);
    bus.fileAddr = 5'h05;
    #1;
    checkOutput("rdPortA", 32'(bus.portRdData), 32'h05);
    checkOutput("hitPortA", 32'(bus.portHit), 32'h1);

    trisBReg = 8'hF0;
    applyStimulus(1'b1, 1'b0, 5'h06, 8'h3C);
    padBIn = 8'h9F;
    stepClocks(SYNC_STAGES);
    bus.fileAddr = 5'h06;
    #1;
    checkOutput("rdMixB", 32'(bus.portRdData), 32'h9C);
    checkOutput("mixPadBOe", 32'(padBOe), 32'h0F);
    checkOutput("mixPadBOut", 32'(padBOut), 32'h3C);

    trisCReg     = 8'hFF;
    padCIn       = 8'h00;
    bus.fileAddr = 5'h07;
    stepClocks(1);
    padCIn = 8'hFF;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stepClocks(1);
      #1;
      checkOutput("latEarlyC", 32'(bus.portRdData), 32'h00);
    end
    stepClocks(1);
    #1;
    checkOutput("latFinalC", 32'(bus.portRdData), 32'hFF);

    // Pads 0x9F under TRIS 0xF0 differ from the zero snapshot, so the flag is already set.
    checkOutput("pbSetByMix", 32'(pbChange), 32'h1);
    trisBReg = 8'hFF;
    padBIn   = 8'h00;
    stepClocks(SYNC_STAGES);
    applyStimulus(1'b0, 1'b1, 5'h06, 8'h00);
    checkOutput("pbClearIdle", 32'(pbChange), 32'h0);

    padBIn = 8'h10;
    stepClocks(SYNC_STAGES);
    #1;
    checkOutput("pbNotYet", 32'(pbChange), 32'h0);
    stepClocks(1);
    #1;
    checkOutput("pbSet", 32'(pbChange), 32'h1);
    applyStimulus(1'b0, 1'b1, 5'h06, 8'h00);
    checkOutput("pbSetWins", 32'(pbChange), 32'h1);
    applyStimulus(1'b0, 1'b1, 5'h06, 8'h00);
    checkOutput("pbCleared", 32'(pbChange), 32'h0);

    trisBReg = 8'hEF;
    padBIn   = 8'h00;
    stepClocks(SYNC_STAGES + 1);
    #1;
    checkOutput("pbMaskFall", 32'(pbChange), 32'h0);
    applyStimulus(1'b0, 1'b1, 5'h06, 8'h00);
    padBIn = 8'h10;
    stepClocks(SYNC_STAGES + 2);
    #1;
    checkOutput("pbMaskRise", 32'(pbChange), 32'h0);
    trisBReg = 8'hFF;
    stepClocks(1);
    #1;
    checkOutput("pbReconfig", 32'(pbChange), 32'h1);

    trisCReg = 8'h00;
    applyStimulus(1'b1, 1'b0, 5'h07, 8'h11);
    bus.wrEn     = 1'b1;
    bus.rdEn     = 1'b1;
    bus.fileAddr = 5'h07;
    bus.wrData   = 8'h22;
    #1;
    checkOutput("rwSameOld", 32'(bus.portRdData), 32'h11);
    @(negedge clk);
    bus.wrEn = 1'b0;
    bus.rdEn = 1'b0;
    #1;
    checkOutput("rwSameNew", 32'(bus.portRdData), 32'h22);

    bus.fileAddr = 5'h08;
    #1;
    checkOutput("rdUnmapped", 32'(bus.portRdData), 32'h00);
    checkOutput("hitUnmapped", 32'(bus.portHit), 32'h0);

    bus.wrEn     = 1'b1;
    bus.fileAddr = 5'h07;
    bus.wrData   = 8'h77;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOe", 32'(padCOe), 32'h00);
    checkOutput("midRstOut", 32'(padCOut), 32'h00);
    @(negedge clk);
    bus.wrEn = 1'b0;
    rst_n    = 1'b1;
    stepClocks(1);
    #1;
    checkOutput("postRstOut", 32'(padCOut), 32'h00);
    checkOutput("postRstOe", 32'(padCOe), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
